// File: rtl/eu_seq_if.sv
// eu_seq operation/result handshake bundle and the shared function encoding.
// Master = producer/consumer side (decode + writeback), slave = eu_seq.

package eu_seq_pkg;
  // Operation select; encodings 11..15 are unsupported and flagged illegal.
  typedef enum logic [3:0] {
    FUNC_ADD  = 4'd0,
    FUNC_ADDI = 4'd1,
    FUNC_SUB  = 4'd2,
    FUNC_AND  = 4'd3,
    FUNC_OR   = 4'd4,
    FUNC_XOR  = 4'd5,
    FUNC_NOT  = 4'd6,
    FUNC_SLL  = 4'd7,
    FUNC_SLLI = 4'd8,
    FUNC_SLR  = 4'd9,
    FUNC_SLRI = 4'd10
  } func_t;
endpackage

interface eu_seq_if
  import eu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 6
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  func_t                 func_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic [IMM_WIDTH-1:0]  imm_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] res_o;
  logic                  zero_o;
  logic                  carry_o;
  logic                  ovf_o;
  logic                  illegal_o;
  logic                  busy_o;

  modport master (
    output in_valid_i, func_i, rs1_data_i, rs2_data_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, zero_o, carry_o, ovf_o, illegal_o, busy_o
  );

  modport slave (
    input  in_valid_i, func_i, rs1_data_i, rs2_data_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, zero_o, carry_o, ovf_o, illegal_o, busy_o
  );
endinterface

// File: rtl/eu_seq.sv
// eu_seq: sequential execution unit (math / gate / shift) with valid/ready
// handshakes and one registered result plus flags.
// Build option: define EU_FAST_SHIFT_EN for a single-cycle barrel shifter;
// otherwise shifts iterate one bit per cycle in a SHIFT state.

module eu_seq
  import eu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 6
) (
  input  logic     clk_i,
  input  logic     arst_ni,
  eu_seq_if.slave  bus
);
  localparam int unsigned SHW  = $clog2(DATA_WIDTH);
  localparam int unsigned SUMW = DATA_WIDTH + 1;
  localparam int unsigned MSB  = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] imm_ext, math_b, alu_res;
  logic [SUMW-1:0]       sum;
  logic                  sub_sel, alu_carry, alu_ovf, alu_illegal, shift_left;
  logic [SHW-1:0]        amt;

  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic                  illegal_q, illegal_d, out_valid_q, out_valid_d;
  logic                  in_ready_c, accept_c, retire_c;

  // Adder operand select: immediate for ADDI, inverted rs2 plus carry-in for SUB
  always_comb begin
    imm_ext = DATA_WIDTH'($signed(bus.imm_i));
    math_b  = bus.rs2_data_i;
    sub_sel = 1'b0;
    case (bus.func_i)
      FUNC_ADDI: math_b = imm_ext;
      FUNC_SUB: begin
        math_b  = ~bus.rs2_data_i;
        sub_sel = 1'b1;
      end
      default: ;
    endcase
    sum = SUMW'(bus.rs1_data_i) + SUMW'(math_b) + SUMW'(sub_sel);
  end

`ifndef EU_FAST_SHIFT_EN
  logic is_shift;
`endif

  // Single-cycle result for the offered operation
  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    shift_left  = 1'b0;
    amt         = bus.rs2_data_i[SHW-1:0];
`ifndef EU_FAST_SHIFT_EN
    is_shift    = 1'b0;
`endif
    case (bus.func_i)
      FUNC_ADD, FUNC_ADDI, FUNC_SUB: begin
        alu_res   = sum[MSB:0];
        alu_carry = sum[DATA_WIDTH];
        alu_ovf   = (bus.rs1_data_i[MSB] == math_b[MSB]) && (sum[MSB] != bus.rs1_data_i[MSB]);
      end
      FUNC_AND: alu_res = bus.rs1_data_i & bus.rs2_data_i;
      FUNC_OR:  alu_res = bus.rs1_data_i | bus.rs2_data_i;
      FUNC_XOR: alu_res = bus.rs1_data_i ^ bus.rs2_data_i;
      FUNC_NOT: alu_res = ~bus.rs1_data_i;
      FUNC_SLL, FUNC_SLLI, FUNC_SLR, FUNC_SLRI: begin
        shift_left = (bus.func_i == FUNC_SLL) || (bus.func_i == FUNC_SLLI);
        if ((bus.func_i == FUNC_SLLI) || (bus.func_i == FUNC_SLRI)) amt = imm_ext[SHW-1:0];
`ifdef EU_FAST_SHIFT_EN
        alu_res = shift_left ? (bus.rs1_data_i << amt) : (bus.rs1_data_i >> amt);
`else
        is_shift = 1'b1;
        alu_res  = bus.rs1_data_i;
`endif
      end
      default: alu_illegal = 1'b1;
    endcase
  end

  assign retire_c       = out_valid_q && bus.out_ready_i;
  assign accept_c       = bus.in_valid_i && in_ready_c;
  assign bus.in_ready_o = in_ready_c;

`ifdef EU_FAST_SHIFT_EN
  assign in_ready_c = !out_valid_q || bus.out_ready_i;
  assign bus.busy_o = 1'b0;

  // Result register update: load on accept, drop valid on retire
  always_comb begin
    res_d       = res_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q && !retire_c;
    if (accept_c) begin
      res_d       = alu_res;
      zero_d      = (alu_res == '0);
      carry_d     = alu_carry;
      ovf_d       = alu_ovf;
      illegal_d   = alu_illegal;
      out_valid_d = 1'b1;
    end
  end
`else
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                state_q, state_d;
  logic [SHW-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] work_q, work_d, work_shift;
  logic                  dir_q, dir_d, busy_q, busy_d;

  assign in_ready_c = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready_i);
  assign bus.busy_o = busy_q;

  // Next state: single-cycle load, or iterate the shift one bit per cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    dir_d       = dir_q;
    busy_d      = 1'b0;
    res_d       = res_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q && !retire_c;
    work_shift  = dir_q ? (work_q << 1) : (work_q >> 1);
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (is_shift && (amt != '0)) begin
            state_d = ST_SHIFT;
            work_d  = bus.rs1_data_i;
            cnt_d   = amt;
            dir_d   = shift_left;
            busy_d  = 1'b1;
          end else begin
            res_d       = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_carry;
            ovf_d       = alu_ovf;
            illegal_d   = alu_illegal;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        work_d = work_shift;
        cnt_d  = cnt_q - SHW'(1);
        busy_d = 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          res_d       = work_shift;
          zero_d      = (work_shift == '0);
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift sequencer registers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
    end
  end
`endif

  // Result and flag registers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      res_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.res_o       = res_q;
  assign bus.zero_o      = zero_q;
  assign bus.carry_o     = carry_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.illegal_o   = illegal_q;
  assign bus.out_valid_o = out_valid_q;

endmodule

// File: tb/tb_eu_seq.sv
// Bench for eu_seq: directed scenarios plus random operations checked
// against an arithmetic reference model. Honours EU_FAST_SHIFT_EN.

module tb_eu_seq;
  import eu_seq_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 6;
`ifdef EU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  eu_seq_if #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) bus ();

  eu_seq #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) dut (
    .clk_i   (clk),
    .arst_ni (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        z, c, o, ill;
    int          cyc;
  } exp_t;

  // Expected result from plain integer arithmetic on the operation's definition
  function automatic exp_t model(func_t f, logic [31:0] a, logic [31:0] b, logic [5:0] imm);
    exp_t        e;
    longint      ua, ub, sa, sb, r;
    logic [31:0] immx;
    int          amt;
    immx  = 32'($signed(imm));
    ua    = longint'(a);
    sa    = longint'($signed(a));
    e.res = '0; e.c = 1'b0; e.o = 1'b0; e.ill = 1'b0; e.cyc = 0;
    case (f)
      FUNC_ADD, FUNC_ADDI: begin
        ub    = (f == FUNC_ADDI) ? longint'(immx) : longint'(b);
        sb    = (f == FUNC_ADDI) ? longint'($signed(imm)) : longint'($signed(b));
        r     = ua + ub;
        e.res = r[31:0];
        e.c   = (r > 64'sd4294967295);
        r     = sa + sb;
        e.o   = (r > SMAX) || (r < SMIN);
      end
      FUNC_SUB: begin
        e.res = a - b;
        e.c   = (a >= b);
        r     = sa - longint'($signed(b));
        e.o   = (r > SMAX) || (r < SMIN);
      end
      FUNC_AND: e.res = a & b;
      FUNC_OR:  e.res = a | b;
      FUNC_XOR: e.res = a ^ b;
      FUNC_NOT: e.res = ~a;
      FUNC_SLL, FUNC_SLLI, FUNC_SLR, FUNC_SLRI: begin
        amt   = ((f == FUNC_SLLI) || (f == FUNC_SLRI)) ? int'(immx % 32) : int'(b % 32);
        e.res = ((f == FUNC_SLL) || (f == FUNC_SLLI)) ? (a << amt) : (a >> amt);
        e.cyc = FAST ? 0 : amt;
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check_result(input string tag, input exp_t e);
    check({tag, " valid"},   bus.out_valid_o, 1);
    check({tag, " res"},     bus.res_o,       e.res);
    check({tag, " zero"},    bus.zero_o,      e.z);
    check({tag, " carry"},   bus.carry_o,     e.c);
    check({tag, " ovf"},     bus.ovf_o,       e.o);
    check({tag, " illegal"}, bus.illegal_o,   e.ill);
    check({tag, " busy"},    bus.busy_o,      0);
  endtask

  // Offer one op, scramble inputs after acceptance, follow it to its result
  task automatic run_op(input string tag, input func_t f, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] imm, output exp_t e);
    e = model(f, a, b, imm);
    @(negedge clk);
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    bus.func_i      = f;
    bus.rs1_data_i  = a;
    bus.rs2_data_i  = b;
    bus.imm_i       = imm;
    #1 check({tag, " in_ready"}, bus.in_ready_o, 1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.func_i     = func_t'(4'($urandom_range(0, 15)));
    bus.rs1_data_i = $urandom;
    bus.rs2_data_i = $urandom;
    bus.imm_i      = 6'($urandom);
    for (int k = 0; k < e.cyc; k++) begin
      check({tag, " busy"},      bus.busy_o,      1);
      check({tag, " !in_ready"}, bus.in_ready_o,  0);
      check({tag, " !valid"},    bus.out_valid_o, 0);
      @(posedge clk);
      #1;
    end
    check_result(tag, e);
  endtask

  // Stall the consumer; result and flags must hold and no new op may enter
  task automatic hold(input string tag, input int n, input exp_t e);
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_result({tag, " held"}, e);
      check({tag, " held in_ready"}, bus.in_ready_o, 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " valid"},    bus.out_valid_o, 0);
    check({tag, " res"},      bus.res_o,       0);
    check({tag, " flags"},    {bus.zero_o, bus.carry_o, bus.ovf_o, bus.illegal_o}, 0);
    check({tag, " busy"},     bus.busy_o,      0);
    check({tag, " in_ready"}, bus.in_ready_o,  1);
  endtask

  initial begin
    exp_t   e;
    func_t  f;
    logic [31:0] a, b;

    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.func_i      = FUNC_ADD;
    bus.rs1_data_i  = '0;
    bus.rs2_data_i  = '0;
    bus.imm_i       = '0;

    #2 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("addi", FUNC_ADDI, 32'd5, 32'd0, 6'b111110, e);
    check("addi const", {bus.res_o, bus.carry_o, bus.zero_o, bus.ovf_o}, {32'd3, 3'b100});

    run_op("add ovf", FUNC_ADD, 32'h7FFF_FFFF, 32'd1, 6'd0, e);
    check("add ovf const", {bus.res_o, bus.ovf_o, bus.carry_o}, {32'h8000_0000, 2'b10});

    run_op("sub zero", FUNC_SUB, 32'd7, 32'd7, 6'd0, e);
    check("sub zero const", {bus.res_o, bus.zero_o, bus.carry_o}, {32'd0, 2'b11});

    run_op("sll5", FUNC_SLL, 32'd1, 32'h25, 6'd0, e);
    check("sll5 const", bus.res_o, 32'h20);

    run_op("slri0", FUNC_SLRI, 32'h8000_0000, 32'd0, 6'd0, e);
    check("slri0 const", bus.res_o, 32'h8000_0000);

    run_op("xor", FUNC_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 6'd0, e);
    check("xor const", bus.res_o, 32'h0000_FF00);
    hold("xor", 3, e);
    run_op("after hold", FUNC_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 6'd0, e);

    run_op("illegal", func_t'(4'd13), 32'h1234_5678, 32'h9, 6'd3, e);
    check("illegal const", {bus.res_o, bus.zero_o, bus.illegal_o}, {32'd0, 2'b11});
    run_op("post illegal", FUNC_ADD, 32'd40, 32'd2, 6'd0, e);

    // Reset during an iterative shift: aborted, no result afterwards
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.func_i     = FUNC_SLR;
    bus.rs1_data_i = 32'hDEAD_BEEF;
    bus.rs2_data_i = 32'd10;
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check("post reset no valid", bus.out_valid_o, 0);
    end
    check("post reset in_ready", bus.in_ready_o, 1);

    for (int i = 0; i < 150; i++) begin
      f = func_t'(4'($urandom_range(0, 15)));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      run_op($sformatf("rand%0d", i), f, a, b, 6'($urandom), e);
      if ($urandom_range(0, 3) == 0) hold($sformatf("rand%0d", i), $urandom_range(1, 3), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eu_seq.md
# eu_seq

Sequential, parametrised execution unit for the simple processor: math (ADD/ADDI/SUB), gate (AND/OR/XOR/NOT) and shift (SLL/SLLI/SLR/SLRI) behind valid/ready handshakes, with one registered result and ALU flags. Shifts run iteratively, one bit per cycle, unless the single-cycle barrel-shift option is compiled in. It sits between decode/register-read and writeback, replacing the purely combinational execution path.

## Interface
- DATA_WIDTH, 32, operand/result width (≥ 4)
- IMM_WIDTH, 6, immediate width; sign-extended to DATA_WIDTH
- clk_i  in  1  clock, all state on rising edge
- arst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operation offered
- in_ready_o  out  1  unit can accept this cycle
- func_i  in  func_t  operation select (package enum)
- rs1_data_i  in  DATA_WIDTH  source 1
- rs2_data_i  in  DATA_WIDTH  source 2 / shift amount
- imm_i  in  IMM_WIDTH  immediate
- out_valid_o  out  1  res_o and flags valid
- out_ready_i  in  1  consumer takes result
- res_o  out  DATA_WIDTH  result
- zero_o / carry_o / ovf_o  out  1 each  result == 0 / carry-out (SUB: 1 = no borrow) / signed overflow
- illegal_o  out  1  accepted func_i not supported
- busy_o  out  1  iterative shift in progress

## Operation
- Handshake: transfer on in_valid_i && in_ready_o; in_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i). Result retires on out_valid_o && out_ready_i.
- Operands, func_i and derived values are captured at acceptance; later input changes have no effect.
- Math: ADD rs1+rs2; ADDI rs1+sext(imm); SUB rs1+~rs2+1. The sum is DATA_WIDTH+1 bits wide; bit DATA_WIDTH is carry_o. ovf_o = operands' sign bits equal (after inversion for SUB) and result sign differs.
- Gate: AND/OR/XOR of rs1, rs2; NOT = ~rs1. carry_o = ovf_o = 0.
- Shift: amount = low $clog2(DATA_WIDTH) bits of rs2 (SLL/SLR) or sext(imm) (SLLI/SLRI). Shifts are logical and zero-fill. carry_o = ovf_o = 0.
- zero_o is computed on the final result for every operation.
- Unsupported func_i: res_o = 0, zero_o = 1, illegal_o = 1, carry_o = ovf_o = 0; completes like a 1-cycle op.
- FSM states:
  - IDLE: accept. Non-shift or amount 0 → result register loaded, stays IDLE. Shift with amount > 0 → working register = rs1, counter = amount, go to SHIFT.
  - SHIFT: busy_o = 1; each cycle shift working register 1 bit and decrement counter. When counter == 1, load result with that cycle's shifted value, set out_valid_o, go to IDLE.
- out_valid_o stays high and res_o/flags stay stable until retired. Accept and retire in the same cycle is allowed: the new result replaces the old one on that edge.

## Timing
- Reset (async assert, sync-released deassert): state IDLE, out_valid_o = 0, res_o = 0, all flags 0, busy_o = 0, counter 0. in_ready_o = 1 after reset.
- Reset mid-SHIFT aborts the operation; no result is produced.
- 1-cycle ops: accepted at edge N → out_valid_o at edge N+1.
- Shift by n > 0: out_valid_o at edge N+n; in_ready_o = 0 for n cycles.
- Throughput: one 1-cycle op per cycle while out_ready_i = 1.
- All outputs are registered except in_ready_o, which is combinational from state, out_valid_o and out_ready_i.

## Configuration
- EU_FAST_SHIFT_EN defined: shifts use a barrel shifter, all ops take 1 cycle, SHIFT state and counter are not built, busy_o is tied to 0.
- EU_FAST_SHIFT_EN undefined (default): iterative 1-bit/cycle shifter as described above.

## Test plan
(All scenarios use DATA_WIDTH = 32, IMM_WIDTH = 6.)
- ADDI rs1=5, imm=6'b111110 → res_o=3, carry_o=1, zero_o=0, ovf_o=0, out_valid_o one cycle after accept.
- ADD 0x7FFFFFFF + 1 → 0x80000000, ovf_o=1, carry_o=0. SUB 7−7 → 0, zero_o=1, carry_o=1.
- SLL rs1=1, rs2=0x25 (amount 5) → 0x20 at accept+5, busy_o and !in_ready_o for 5 cycles. SLRI rs1=0x80000000, imm=0 → same value after 1 cycle. With EU_FAST_SHIFT_EN, the SLL result arrives at accept+1.
- Backpressure: XOR 0xF0F0 ^ 0x0FF0 (→ 0xFF00) with out_ready_i=0 for 3 cycles → res_o held, in_ready_o=0. Raise out_ready_i with the next op valid → retire and accept on the same edge.
- Assert arst_ni at cycle 2 of SLR by 10 → all outputs 0 immediately; after release, in_ready_o=1 and no stale out_valid_o.
- Unsupported func_i value → illegal_o=1, res_o=0, zero_o=1 after 1 cycle, then normal ops continue.
